// File: rtl/even_pair_reader_if.sv
// Pair stream from even_pair_reader to the check-node stage.
// The source side (master) drives valid/data/last; the sink (slave) drives ready.
interface even_pair_reader_if #(
    parameter int DATA_W = 24
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data_a;
    logic [DATA_W-1:0] out_data_b;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data_a,
        output out_data_b,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data_a,
        input  out_data_b,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/even_pair_reader.sv
// even_pair_reader: walks the even address stream of an external counter_even,
// fetches word pairs (2k, 2k+1) from a dual-port RAM with 1-cycle read latency
// and hands them downstream through a 2-entry valid/ready buffer.
// A read is only issued when a buffer slot is guaranteed free on return, so the
// buffer can never overflow.
// Optional build macro: PAIR_RD_STALL_CNT_EN adds a per-frame backpressure
// counter output stall_cnt[15:0].
module even_pair_reader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] num_pairs,
    output logic              cnt_rst,
    output logic              cnt_en,
    input  logic [ADDR_W-1:0] count,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic [ADDR_W-1:0] ram_addr_b,
    input  logic [DATA_W-1:0] ram_dout_a,
    input  logic [DATA_W-1:0] ram_dout_b,
    even_pair_reader_if.master out_if,
    output logic              busy,
    output logic              done
`ifdef PAIR_RD_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] MAX_PAIRS = {1'b1, {(ADDR_W-1){1'b0}}};
    localparam logic [ADDR_W-1:0] ONE_A     = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ZERO_A    = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] ZERO_D    = {DATA_W{1'b0}};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] remaining_q, remaining_d;
    logic              inflight_q;
    logic              inflight_last_q;
    logic [DATA_W-1:0] fifo_a_q [2];
    logic [DATA_W-1:0] fifo_b_q [2];
    logic              fifo_last_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        fifo_cnt_q;

    logic              out_valid_s;
    logic              pop_s;
    logic              credit_s;
    logic              issue_s;
    logic              last_issue_s;

    // Head of the buffer is presented directly from the storage registers
    assign out_valid_s       = (fifo_cnt_q != 2'd0);
    assign out_if.out_valid  = out_valid_s;
    assign out_if.out_data_a = fifo_a_q[rd_ptr_q];
    assign out_if.out_data_b = fifo_b_q[rd_ptr_q];
    assign out_if.out_last   = out_valid_s & fifo_last_q[rd_ptr_q];

    assign pop_s        = out_valid_s & out_if.out_ready;
    // A slot is free on return if occupancy plus the read in flight is below 2,
    // or if the head leaves this cycle.
    assign credit_s     = ((fifo_cnt_q + {1'b0, inflight_q}) < 2'd2) | pop_s;
    assign issue_s      = (state_q == ST_RUN) & (remaining_q != ZERO_A) & credit_s;
    assign last_issue_s = (remaining_q == ONE_A);

    assign cnt_en     = issue_s;
    assign ram_re     = issue_s;
    assign ram_addr_a = issue_s ? count : ZERO_A;
    assign ram_addr_b = issue_s ? (count | ONE_A) : ZERO_A;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);

    // Next-state and frame bookkeeping for the fetch sequencer
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        cnt_rst     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_INIT;
                    remaining_d = (num_pairs > MAX_PAIRS) ? MAX_PAIRS : num_pairs;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_INIT: begin
                cnt_rst = 1'b1;
                if (remaining_q == ZERO_A) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (issue_s) begin
                    remaining_d = remaining_q - ONE_A;
                    if (last_issue_s) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!inflight_q && (fifo_cnt_q == 2'd0)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                remaining_d = ZERO_A;
            end
        endcase
    end

    // Sequencer state and remaining-pair count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= ZERO_A;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

    // Return path: capture RAM data one cycle after issue, retire head on transfer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            fifo_a_q[0]     <= ZERO_D;
            fifo_a_q[1]     <= ZERO_D;
            fifo_b_q[0]     <= ZERO_D;
            fifo_b_q[1]     <= ZERO_D;
            fifo_last_q[0]  <= 1'b0;
            fifo_last_q[1]  <= 1'b0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            fifo_cnt_q      <= 2'd0;
        end else begin
            inflight_q      <= issue_s;
            inflight_last_q <= issue_s & last_issue_s;
            if (inflight_q) begin
                fifo_a_q[wr_ptr_q]    <= ram_dout_a;
                fifo_b_q[wr_ptr_q]    <= ram_dout_b;
                fifo_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({inflight_q, pop_s})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

`ifdef PAIR_RD_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    // Per-frame count of backpressured cycles, saturating, kept after frame end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= 16'h0000;
        end else if (state_q == ST_INIT) begin
            stall_cnt_q <= 16'h0000;
        end else if (out_valid_s && !out_if.out_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'h0001;
        end else begin
            stall_cnt_q <= stall_cnt_q;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_even_pair_reader.sv
// Bench for even_pair_reader: models counter_even and the dual-port RAM, and
// predicts the pair stream of each frame from the RAM contents directly.
module tb_even_pair_reader;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 24;
    localparam int MAXP   = 512;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              last;
    } pair_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] num_pairs = '0;
    logic              cnt_rst, cnt_en, ram_re, busy, done;
    logic [ADDR_W-1:0] count = 10'd100;
    logic [ADDR_W-1:0] ram_addr_a, ram_addr_b;
    logic [DATA_W-1:0] ram_dout_a = '0;
    logic [DATA_W-1:0] ram_dout_b = '0;
`ifdef PAIR_RD_STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif
    logic [DATA_W-1:0] mem [0:1023];

    int total = 0;
    int bad   = 0;
    int st_got, st_issued, st_done, st_done_cycle, st_busy;
    int st_first_issue, st_last_issue, st_first_xfer, st_last_xfer;
    int st_max_occ, st_issue_stalled;
    logic [ADDR_W-1:0] st_last_a, st_last_b;

    even_pair_reader_if #(.DATA_W(DATA_W)) sif ();

    even_pair_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_pairs  (num_pairs),
        .cnt_rst    (cnt_rst),
        .cnt_en     (cnt_en),
        .count      (count),
        .ram_re     (ram_re),
        .ram_addr_a (ram_addr_a),
        .ram_addr_b (ram_addr_b),
        .ram_dout_a (ram_dout_a),
        .ram_dout_b (ram_dout_b),
        .out_if     (sif.master),
        .busy       (busy),
        .done       (done)
`ifdef PAIR_RD_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    // counter_even model: synchronous active-high reset, +2 per enable
    always @(posedge clk) begin
        if (cnt_rst) count <= '0;
        else if (cnt_en) count <= count + 10'd2;
    end

    // Dual-port RAM model with one cycle of read latency
    always @(posedge clk) begin
        if (ram_re) begin
            ram_dout_a <= mem[ram_addr_a];
            ram_dout_b <= mem[ram_addr_b];
        end
    end

    // Run one frame of n pairs. mode 0: ready high; 1: random ready;
    // 2: ready low for stall_len cycles from the first valid. restart_at>0
    // pulses start again on that cycle (must be ignored).
    task automatic run_frame(input int n, input int mode, input int stall_len, input int restart_at);
        pair_t exp_q[$];
        pair_t e;
        int en, i, post, stall_left, occ;
        bit stall_started, seen_done;
        logic pv, pr, pl;
        logic [DATA_W-1:0] pa, pb;
        en = (n > MAXP) ? MAXP : n;
        exp_q = {};
        for (int k = 0; k < en; k++) begin
            e.a = mem[2*k];
            e.b = mem[2*k+1];
            e.last = (k == en - 1);
            exp_q.push_back(e);
        end
        st_got = 0; st_issued = 0; st_done = 0; st_done_cycle = -1; st_busy = 0;
        st_first_issue = -1; st_last_issue = -1; st_first_xfer = -1; st_last_xfer = -1;
        st_max_occ = 0; st_issue_stalled = 0; st_last_a = '0; st_last_b = '0;
        stall_started = 1'b0; stall_left = 0; seen_done = 1'b0; post = 0; i = 0;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pa = '0; pb = '0;
        @(negedge clk);
        start = 1'b1;
        num_pairs = ADDR_W'(n);
        sif.out_ready = 1'b1;
        while (1) begin
            @(negedge clk);
            i++;
            start = (i == restart_at);
            if (i == restart_at) num_pairs = 10'd5;
            case (mode)
                0: sif.out_ready = 1'b1;
                1: sif.out_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (!stall_started && sif.out_valid === 1'b1) begin
                        stall_started = 1'b1;
                        stall_left = stall_len;
                    end
                    if (stall_left > 0) begin
                        sif.out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        sif.out_ready = 1'b1;
                    end
                end
            endcase
            #1;
            total++;
            if (cnt_en !== ram_re) begin
                bad++; $display("FAIL cnt_en_vs_re: cycle %0d cnt_en=%b ram_re=%b", i, cnt_en, ram_re);
            end
            total++;
            if (cnt_rst !== 1'(i == 1)) begin
                bad++; $display("FAIL cnt_rst: cycle %0d got %b expected %b", i, cnt_rst, (i == 1));
            end
            if (ram_re === 1'b1) begin
                total++;
                if (ram_addr_a !== ADDR_W'(2*st_issued) || ram_addr_b !== ADDR_W'(2*st_issued+1)) begin
                    bad++; $display("FAIL addr: got a=%0d b=%0d expected a=%0d b=%0d",
                                    ram_addr_a, ram_addr_b, 2*st_issued, 2*st_issued+1);
                end
                total++;
                if (st_issued >= en) begin
                    bad++; $display("FAIL extra_issue: issue %0d of %0d", st_issued + 1, en);
                end
                if (st_first_issue < 0) st_first_issue = i;
                st_last_issue = i;
                st_last_a = ram_addr_a;
                st_last_b = ram_addr_b;
                if (sif.out_ready !== 1'b1) st_issue_stalled++;
                st_issued++;
            end
            if (pv && !pr) begin
                total++;
                if (sif.out_valid !== 1'b1 || sif.out_data_a !== pa || sif.out_data_b !== pb || sif.out_last !== pl) begin
                    bad++; $display("FAIL hold: cycle %0d got v=%b a=%h b=%h l=%b expected v=1 a=%h b=%h l=%b",
                                    i, sif.out_valid, sif.out_data_a, sif.out_data_b, sif.out_last, pa, pb, pl);
                end
            end
            if (sif.out_valid === 1'b1 && sif.out_ready === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL extra_pair: got a=%h b=%h expected none", sif.out_data_a, sif.out_data_b);
                end else begin
                    e = exp_q.pop_front();
                    if (sif.out_data_a !== e.a || sif.out_data_b !== e.b || sif.out_last !== e.last) begin
                        bad++; $display("FAIL pair%0d: got a=%h b=%h l=%b expected a=%h b=%h l=%b",
                                        st_got, sif.out_data_a, sif.out_data_b, sif.out_last, e.a, e.b, e.last);
                    end
                end
                if (st_first_xfer < 0) st_first_xfer = i;
                st_last_xfer = i;
                st_got++;
            end
            occ = st_issued - st_got;
            if (occ > st_max_occ) st_max_occ = occ;
            if (busy === 1'b1) st_busy++;
            if (done === 1'b1) begin
                st_done++;
                if (!seen_done) st_done_cycle = i;
                seen_done = 1'b1;
            end
            pv = sif.out_valid; pr = sif.out_ready; pl = sif.out_last;
            pa = sif.out_data_a; pb = sif.out_data_b;
            if (seen_done) post++;
            if (post == 3) break;
            if (i >= 4000) begin
                total++; bad++;
                $display("FAIL timeout: no done after %0d cycles, expected done", i);
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b expected 0", done); end
        total++; if (ram_re !== 1'b0 || cnt_en !== 1'b0 || cnt_rst !== 1'b0) begin
            bad++; $display("FAIL rst_ctrl: got re=%b en=%b crst=%b expected 0", ram_re, cnt_en, cnt_rst); end
        total++; if (sif.out_valid !== 1'b0 || sif.out_last !== 1'b0) begin
            bad++; $display("FAIL rst_valid: got v=%b l=%b expected 0", sif.out_valid, sif.out_last); end
        total++; if (sif.out_data_a !== '0 || sif.out_data_b !== '0) begin
            bad++; $display("FAIL rst_data: got a=%h b=%h expected 0", sif.out_data_a, sif.out_data_b); end
`ifdef PAIR_RD_STALL_CNT_EN
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL rst_stall: got %0d expected 0", stall_cnt); end
`endif
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic();
        run_frame(4, 0, 0, 0);
        total++; if (st_got !== 4 || st_issued !== 4) begin
            bad++; $display("FAIL basic_count: got %0d pairs %0d issues expected 4", st_got, st_issued); end
        total++; if (st_first_issue !== 2 || st_last_issue - st_first_issue !== 3) begin
            bad++; $display("FAIL basic_issue: got first=%0d last=%0d expected 2..5", st_first_issue, st_last_issue); end
        total++; if (st_first_xfer - st_first_issue !== 2 || st_last_xfer - st_first_xfer !== 3) begin
            bad++; $display("FAIL basic_xfer: got first=%0d last=%0d expected %0d..%0d",
                            st_first_xfer, st_last_xfer, st_first_issue + 2, st_first_issue + 5); end
        total++; if (st_done !== 1) begin bad++; $display("FAIL basic_done: got %0d expected 1", st_done); end
    endtask

    task automatic test_backpressure();
        run_frame(3, 2, 5, 0);
        total++; if (st_got !== 3) begin bad++; $display("FAIL bp_count: got %0d expected 3", st_got); end
        total++; if (st_max_occ > 2) begin bad++; $display("FAIL bp_occ: got %0d expected <=2", st_max_occ); end
        total++; if (st_issue_stalled !== 0) begin
            bad++; $display("FAIL bp_issue: got %0d issues while stalled expected 0", st_issue_stalled); end
        total++; if (st_done !== 1) begin bad++; $display("FAIL bp_done: got %0d expected 1", st_done); end
    endtask

    task automatic test_zero();
        run_frame(0, 0, 0, 0);
        total++; if (st_issued !== 0 || st_got !== 0) begin
            bad++; $display("FAIL zero_traffic: got %0d issues %0d pairs expected 0", st_issued, st_got); end
        total++; if (st_done_cycle !== 2 || st_done !== 1) begin
            bad++; $display("FAIL zero_done: got cycle %0d count %0d expected cycle 2 count 1", st_done_cycle, st_done); end
        total++; if (st_busy !== 2) begin bad++; $display("FAIL zero_busy: got %0d expected 2", st_busy); end
    endtask

    task automatic test_saturate();
        run_frame(600, 0, 0, 0);
        total++; if (st_got !== MAXP || st_issued !== MAXP) begin
            bad++; $display("FAIL sat_count: got %0d pairs %0d issues expected %0d", st_got, st_issued, MAXP); end
        total++; if (st_last_a !== 10'd1022 || st_last_b !== 10'd1023) begin
            bad++; $display("FAIL sat_addr: got %0d,%0d expected 1022,1023", st_last_a, st_last_b); end
        total++; if (st_done !== 1) begin bad++; $display("FAIL sat_done: got %0d expected 1", st_done); end
    endtask

    task automatic test_start_ignored();
        run_frame(6, 0, 0, 4);
        total++; if (st_got !== 6 || st_issued !== 6 || st_done !== 1) begin
            bad++; $display("FAIL restart: got pairs=%0d issues=%0d done=%0d expected 6,6,1", st_got, st_issued, st_done); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; num_pairs = 10'd20; sif.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || ram_re !== 1'b0 || sif.out_valid !== 1'b0 || sif.out_last !== 1'b0) begin
            bad++; $display("FAIL midrst_ctrl: got busy=%b re=%b v=%b l=%b expected 0", busy, ram_re, sif.out_valid, sif.out_last); end
        total++; if (sif.out_data_a !== '0 || sif.out_data_b !== '0) begin
            bad++; $display("FAIL midrst_data: got a=%h b=%h expected 0", sif.out_data_a, sif.out_data_b); end
        @(negedge clk);
        reset = 1'b1;
        run_frame(3, 0, 0, 0);
        total++; if (st_got !== 3 || st_done !== 1) begin
            bad++; $display("FAIL midrst_after: got pairs=%0d done=%0d expected 3,1", st_got, st_done); end
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            int n;
            n = $urandom_range(1, 40);
            run_frame(n, 1, 0, 0);
            total++; if (st_got !== n || st_done !== 1 || st_max_occ > 2) begin
                bad++; $display("FAIL rand%0d: got pairs=%0d done=%0d occ=%0d expected %0d,1,<=2",
                                f, st_got, st_done, st_max_occ, n); end
        end
    endtask

`ifdef PAIR_RD_STALL_CNT_EN
    task automatic test_stall_cnt();
        int w;
        run_frame(5, 2, 7, 0);
        total++; if (stall_cnt !== 16'd7) begin bad++; $display("FAIL stall_val: got %0d expected 7", stall_cnt); end
        @(negedge clk); #1;
        total++; if (stall_cnt !== 16'd7) begin bad++; $display("FAIL stall_hold: got %0d expected 7", stall_cnt); end
        @(negedge clk);
        start = 1'b1; num_pairs = 10'd1; sif.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk); #1;
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL stall_clear: got %0d expected 0", stall_cnt); end
        w = 0;
        while (done !== 1'b1 && w < 50) begin @(negedge clk); #1; w++; end
        total++; if (w >= 50) begin bad++; $display("FAIL stall_timeout: got no done expected done"); end
    endtask
`endif

    // Test sequence
    initial begin
        for (int k = 0; k < 1024; k++) mem[k] = DATA_W'($urandom);
        sif.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_zero();
        test_saturate();
        test_start_ignored();
        test_reset_mid();
        test_random();
`ifdef PAIR_RD_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
